// File: rtl/usb_pkg.sv
// Shared USB definitions: ULPI transmit state encoding, PID values and
// the TX CMD byte layout used by the link-side transmitter.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    STOP,
    ABORT
  } ulpi_tx_state_t;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [1:0] TXCMD_PREFIX = 2'b01;

  // TX CMD byte: command prefix, two reserved zero bits, then the PID.
  function automatic logic [7:0] txcmd_byte(input logic [1:0] prefix,
                                            input logic [3:0] pid);
    return {prefix, 2'b00, pid};
  endfunction

endpackage

// File: rtl/ulpi_beat_detect.sv
// Rising-edge detector on the oversampled ULPI clock; one beat per
// ulpi_clk period in the clk domain.
module ulpi_beat_detect (
  input  logic clk,
  input  logic rst,
  input  logic ulpi_clk,
  output logic beat
);

  logic ulpi_clk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ulpi_clk_q <= 1'b0;
    end else begin
      ulpi_clk_q <= ulpi_clk;
    end
  end

  assign beat = ulpi_clk & ~ulpi_clk_q;

endmodule

// File: rtl/usb_ulpi_tx.sv
// Link-side ULPI transmitter: TX CMD, paced payload bytes and stp, with
// the bus surrendered as soon as the PHY claims it through dir.
module usb_ulpi_tx
  import usb_pkg::*;
#(
  parameter logic [1:0] TXCMD_PREFIX = usb_pkg::TXCMD_PREFIX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_clk,
  input  logic       dir,
  input  logic       nxt,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_pid_only,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       stp,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       tx_err
);

  ulpi_tx_state_t state;
  logic           beat;
  logic           pending;
  logic [3:0]     pid_q;
  logic           pid_only_q;

  ulpi_beat_detect u_beat (
    .clk      (clk),
    .rst      (rst),
    .ulpi_clk (ulpi_clk),
    .beat     (beat)
  );

  // A PHY turnaround in any driving state wins over whatever the beat
  // would have done; the request is only retired once the bus is back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      pid_q      <= 4'h0;
      pid_only_q <= 1'b0;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      tx_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start && !pending) begin
            pending    <= 1'b1;
            pid_q      <= tx_pid;
            pid_only_q <= tx_pid_only;
          end
          if (beat && pending && !dir) begin
            state <= CMD;
          end
        end
        CMD: begin
          if (dir) begin
            state    <= ABORT;
            tx_abort <= 1'b1;
          end else if (beat && nxt) begin
            state <= pid_only_q ? STOP : DATA;
          end
        end
        DATA: begin
          if (dir) begin
            state    <= ABORT;
            tx_abort <= 1'b1;
          end else if (beat && nxt) begin
            if (!tx_valid) begin
              tx_err <= 1'b1;
              state  <= STOP;
            end else if (tx_last) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (dir) begin
            state    <= ABORT;
            tx_abort <= 1'b1;
          end else if (beat) begin
            state   <= IDLE;
            pending <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        ABORT: begin
          if (!dir) begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    data_oe  = 1'b0;
    stp      = 1'b0;
    case (state)
      CMD: begin
        data_out = txcmd_byte(TXCMD_PREFIX, pid_q);
        data_oe  = 1'b1;
      end
      DATA: begin
        data_out = tx_data;
        data_oe  = 1'b1;
      end
      STOP: begin
        stp     = 1'b1;
        data_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_ready = (state == DATA) && beat && nxt && tx_valid;
  assign tx_busy  = pending || (state != IDLE);

endmodule

// File: tb/tb_usb_ulpi_tx.sv
// Randomised packet bench for usb_ulpi_tx: the expected bus byte stream and
// handshake counts are derived per packet from the packet description.
module tb_usb_ulpi_tx;
  import usb_pkg::*;

  logic       clk = 1'b0;
  logic       rst, ulpi_clk, dir, nxt, tx_start, tx_pid_only, tx_valid, tx_last;
  logic [3:0] tx_pid;
  logic [7:0] tx_data, data_out;
  logic       tx_ready, data_oe, stp, tx_busy, tx_done, tx_abort, tx_err;

  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  logic       uPrev = 1'b0;
  logic       beat = 1'b0;
  logic [7:0] payload [16];

  usb_ulpi_tx dut (
    .clk(clk), .rst(rst), .ulpi_clk(ulpi_clk), .dir(dir), .nxt(nxt),
    .tx_start(tx_start), .tx_pid(tx_pid), .tx_pid_only(tx_pid_only),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .data_out(data_out), .data_oe(data_oe), .stp(stp),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_abort(tx_abort), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // One bench cycle: inputs change at negedge; ulpi_clk has period 4 clk.
  task automatic step();
    @(negedge clk);
    cyc++;
    uPrev    = ulpi_clk;
    ulpi_clk = ((cyc % 4) >= 2);
    beat     = ulpi_clk && !uPrev;
    tx_start = 1'b0;
  endtask

  task automatic releaseReset();
    for (int i = 0; i < 8; i++) begin
      step();
      rst = ulpi_clk;
      #1;
      if (!rst) break;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pid, input bit pidOnly, input int nBytes,
                               input int nxtPct, input int underrunAt, input int abortAt,
                               input int stallIdx, input int stallBeats,
                               input bit deferStart, input bit retrigger);
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] cmdByte;
    int  idx = 0, readyCnt = 0, doneCnt = 0, errCnt = 0, abortCnt = 0;
    int  stpBeats = 0, stpBad = 0, doneBad = 0, errNoStp = 0, tailDrive = 0;
    int  startCyc = 0, cmdCyc = -1, firstDrive = -1, dirRose = -1, abortOk = 0;
    int  stallLeft = stallBeats, stallSeen = 0, deferViol = 0, expReady = 0, n = 0;
    bit  finished = 0, underrun = 0, aborted = 0;

    cmdByte  = 8'h40 + {4'h0, pid};
    aborted  = (abortAt >= 0);
    underrun = !pidOnly && !aborted && (underrunAt >= 0) && (underrunAt < nBytes);

    step();
    startCyc    = cyc;
    tx_start    = 1'b1;
    tx_pid      = pid;
    tx_pid_only = pidOnly;
    dir         = deferStart;
    nxt         = 1'b0;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    #1;
    checkOutput("startNoDrive", data_oe, 0);

    for (int k = 0; k < 600 && !finished; k++) begin
      step();
      if (aborted && dirRose < 0 && idx == abortAt && data_oe && !stp) dirRose = cyc;
      dir = (deferStart && cyc < startCyc + 10) || (dirRose >= 0 && cyc < dirRose + 5);
      if (dirRose == cyc) nxt = 1'b0;
      else if (stallIdx >= 0 && idx == stallIdx && stallLeft > 0 && beat && data_oe && !stp) begin
        nxt = 1'b0;
        stallLeft--;
      end
      else if (beat) nxt = ($urandom_range(99) < nxtPct);
      else nxt = 1'($urandom_range(1));
      tx_valid = (idx != underrunAt);
      tx_data  = (idx < nBytes) ? payload[idx] : 8'h00;
      tx_last  = (idx == nBytes - 1);
      if (retrigger && cyc == startCyc + 3) begin
        tx_start    = 1'b1;
        tx_pid      = ~pid;
        tx_pid_only = ~pidOnly;
      end
      #1;
      if (data_oe && firstDrive < 0) firstDrive = cyc;
      if (cmdCyc < 0 && beat && !dir) cmdCyc = cyc + 1;
      if (beat && data_oe && !dir) begin
        if (stp) begin
          stpBeats++;
          if (data_out != 8'h00) stpBad++;
        end else begin
          if (nxt) got.push_back(data_out);
          if (stallIdx >= 0 && idx == stallIdx && data_out == payload[stallIdx]) stallSeen++;
        end
      end
      if (tx_ready) begin readyCnt++; idx++; end
      if (tx_done) begin doneCnt++; if (data_oe || stp || tx_busy) doneBad++; end
      if (tx_err) begin errCnt++; if (!stp) errNoStp++; end
      if (tx_abort) abortCnt++;
      if (dirRose >= 0 && cyc == dirRose + 1) abortOk = (!data_oe && tx_abort) ? 1 : 0;
      if (deferStart && cyc < startCyc + 10 && (data_oe || !tx_busy)) deferViol++;
      if (!tx_busy && !dir) finished = 1;
    end
    if (!finished) checkOutput("timeout", 0, 1);

    for (int k = 0; k < 8; k++) begin
      step();
      dir = 1'b0; nxt = 1'($urandom_range(1)); tx_valid = 1'b0; tx_last = 1'b0;
      #1;
      if (data_oe) tailDrive++;
      if (tx_done) doneCnt++;
      if (tx_err) errCnt++;
      if (tx_abort) abortCnt++;
    end

    exp.push_back(cmdByte);
    if (!pidOnly) begin
      expReady = aborted ? abortAt : (underrun ? underrunAt : nBytes);
      for (int i = 0; i < expReady; i++) exp.push_back(payload[i]);
      if (underrun) exp.push_back(payload[underrunAt]);
    end
    n = (got.size() < exp.size()) ? got.size() : exp.size();

    checkOutput("cmdLatency", firstDrive, cmdCyc);
    checkOutput("byteCount", got.size(), exp.size());
    for (int i = 0; i < n; i++) checkOutput($sformatf("byte%0d", i), got[i], exp[i]);
    checkOutput("readyCount", readyCnt, expReady);
    checkOutput("doneCount", doneCnt, aborted ? 0 : 1);
    checkOutput("doneIdle", doneBad, 0);
    checkOutput("errCount", errCnt, underrun ? 1 : 0);
    checkOutput("errWithStp", errNoStp, 0);
    checkOutput("abortCount", abortCnt, aborted ? 1 : 0);
    checkOutput("stopBeats", stpBeats, aborted ? 0 : 1);
    checkOutput("stopData", stpBad, 0);
    checkOutput("tailIdle", tailDrive, 0);
    if (aborted) checkOutput("abortEntry", abortOk, 1);
    if (stallIdx >= 0) checkOutput("stallHold", stallSeen, stallBeats + 1);
    if (deferStart) checkOutput("deferHold", deferViol, 0);
  endtask

  task automatic resetMidData();
    int idx = 0;
    bit hit = 0;
    int stray = 0;
    for (int i = 0; i < 8; i++) payload[i] = 8'($urandom);
    step();
    tx_start = 1'b1; tx_pid = PID_DATA1; tx_pid_only = 1'b0; dir = 1'b0; nxt = 1'b0;
    #1;
    for (int k = 0; k < 200 && !hit; k++) begin
      step();
      nxt = beat; tx_valid = 1'b1; tx_data = payload[idx]; tx_last = (idx == 7);
      #1;
      if (tx_ready) idx++;
      if (idx == 2 && data_oe && !stp) hit = 1;
    end
    checkOutput("resetReached", hit, 1);
    step();
    rst = 1'b1; nxt = beat; tx_data = payload[idx];
    #1;
    step();
    nxt = beat;
    #1;
    checkOutput("resetMidData",
                {data_out, data_oe, stp, tx_busy, tx_done, tx_abort, tx_err, tx_ready}, 0);
    releaseReset();
    for (int k = 0; k < 8; k++) begin
      step();
      nxt = beat; tx_valid = 1'b0;
      #1;
      if (stp || data_oe || tx_busy || tx_done) stray++;
    end
    checkOutput("resetNoStp", stray, 0);
  endtask

  initial begin
    rst = 1'b1; ulpi_clk = 1'b0; dir = 1'b0; nxt = 1'b0; tx_start = 1'b0;
    tx_pid = 4'h0; tx_pid_only = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); rst = 1'b1; #1; end
    checkOutput("resetState",
                {data_out, data_oe, stp, tx_busy, tx_done, tx_abort, tx_err, tx_ready}, 0);
    releaseReset();
    checkOutput("resetIdle",
                {data_out, data_oe, stp, tx_busy, tx_done, tx_abort, tx_err, tx_ready}, 0);

    payload[0] = 8'hA5; payload[1] = 8'h5A; payload[2] = 8'hFF;
    $display("[TB] ACK handshake");
    applyStimulus(PID_ACK, 1, 0, 100, -1, -1, -1, 0, 0, 0);
    $display("[TB] DATA0 three bytes");
    applyStimulus(PID_DATA0, 0, 3, 100, -1, -1, -1, 0, 0, 0);
    $display("[TB] DATA0 with stall on byte 2");
    applyStimulus(PID_DATA0, 0, 3, 100, -1, -1, 1, 2, 0, 1);
    $display("[TB] PHY takes bus during byte 2");
    applyStimulus(PID_DATA0, 0, 3, 100, -1, 1, -1, 0, 0, 0);
    $display("[TB] payload underrun");
    applyStimulus(PID_DATA0, 0, 3, 100, 1, -1, -1, 0, 0, 0);
    $display("[TB] deferred start under dir");
    applyStimulus(PID_DATA1, 0, 3, 100, -1, -1, -1, 0, 1, 0);
    $display("[TB] reset mid-packet");
    resetMidData();

    $display("[TB] random packets");
    for (int p = 0; p < 12; p++) begin
      bit pidOnly;
      int nBytes, underrunAt, abortAt;
      pidOnly    = ($urandom_range(3) == 0);
      nBytes     = pidOnly ? 0 : int'($urandom_range(8, 1));
      for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
      underrunAt = (!pidOnly && $urandom_range(3) == 0) ? int'($urandom_range(nBytes - 1, 0)) : -1;
      abortAt    = (!pidOnly && underrunAt < 0 && nBytes >= 2 && $urandom_range(3) == 0)
                   ? int'($urandom_range(nBytes - 1, 1)) : -1;
      applyStimulus(4'($urandom), pidOnly, nBytes, 60, underrunAt, abortAt, -1, 0,
                    ($urandom_range(3) == 0), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/usb_ulpi_tx.md
# usb_ulpi_tx

Link-side ULPI transmit controller: takes a packet (PID plus optional payload bytes) from the USB protocol layer and drives it onto the ULPI data bus as a TX CMD followed by data bytes, pacing on the PHY's `nxt` and terminating with `stp`. It is the transmit counterpart of the ULPI receive state machine and shares the same bus pins, clock and `ulpi_clk` oversampling scheme. It yields the bus whenever the PHY asserts `dir`.

## Interface
Parameters:
- `TXCMD_PREFIX`, 2'b01: upper two bits of the TX CMD byte (transmit command).

Ports:
- `clk`  in  1  system clock; oversamples `ulpi_clk`
- `rst`  in  1  synchronous, active-high reset
- `ulpi_clk`  in  1  PHY clock, sampled in the `clk` domain
- `dir`  in  1  PHY bus direction; 1 = PHY owns the bus
- `nxt`  in  1  PHY throttle; 1 = current byte accepted this beat
- `tx_start`  in  1  one-`clk` pulse requesting a packet; honoured only in IDLE with no request pending
- `tx_pid`  in  4  PID; latched on `tx_start`
- `tx_pid_only`  in  1  1 = handshake or token packet with no payload; latched on `tx_start`
- `tx_data`  in  8  current payload byte
- `tx_valid`  in  1  `tx_data` valid
- `tx_last`  in  1  `tx_data` is the final payload byte
- `tx_ready`  out  1  one-`clk` pulse; payload byte consumed
- `data_out`  out  8  ULPI data driven by the link
- `data_oe`  out  1  link drives the ULPI data bus
- `stp`  out  1  ULPI stop
- `tx_busy`  out  1  request pending, or state not IDLE
- `tx_done`  out  1  one-`clk` pulse; packet completed
- `tx_abort`  out  1  one-`clk` pulse; PHY took the bus mid-packet
- `tx_err`  out  1  one-`clk` pulse; payload underrun

## Operation
- **Beat:** a `clk` cycle in which `ulpi_clk` was 0 on the previous `clk` and is 1 now. All state transitions happen on beats, except entry to ABORT.
- **States and transitions:**
  - IDLE: `tx_start` latches PID, `pid_only` and sets `pending`. On a beat with `pending` and `dir==0`, go to CMD.
  - CMD: `data_out = {TXCMD_PREFIX, 2'b00, pid}`, `data_oe=1`. On a beat with `nxt`, go to STOP if `pid_only`, otherwise go to DATA.
  - DATA: `data_out = tx_data`, `data_oe=1`. On a beat with `nxt`:
    - if `tx_valid`, pulse `tx_ready`; if `tx_last` is also set, go to STOP.
    - if `!tx_valid`, pulse `tx_err` and go to STOP (underrun).
  - STOP: `data_out = 8'h00`, `stp=1`, `data_oe=1`. On the next beat, go to IDLE and pulse `tx_done`; clear `pending`.
  - ABORT: `data_oe=0`, `data_out=0`. On the first `clk` with `dir==0`, go to IDLE; clear `pending`.
- **Abort entry:** `dir==1` in any `clk` of CMD, DATA or STOP sends the block to ABORT on the next `clk` and pulses `tx_abort`. Abort takes priority over every beat transition in the same cycle. No `tx_done` is issued for an aborted packet.
- **Deferred start:** `dir==1` while IDLE with `pending` set keeps the request pending. Transmission starts on the first beat with `dir==0`.
- **Ignored requests:** `tx_start` outside IDLE, or while `pending` is already set, is ignored.
- **Reset:** mid-packet reset returns to IDLE within one `clk` and clears `pending`. No `stp` is issued.
- **Output reset values:** all outputs 0; state IDLE.

## Timing
- Outputs are Moore functions of the state register, except:
  - `data_out` in DATA passes `tx_data` through.
  - `tx_ready` is `(DATA & beat & nxt & tx_valid)`, combinational.
- Pulse outputs (`tx_done`, `tx_abort`, `tx_err`) are registered and last exactly one `clk`.
- Latency from `tx_start` (with `dir==0`) to TX CMD on the bus: first beat after the `tx_start` cycle.
- Each byte is held until a beat with `nxt==1`. Beats with `nxt==0` hold state.
- Beats per packet with no stalls: 1 CMD + N data + 1 STOP.
- `tx_err` and the STOP entry occur on the same beat.

## Structure
- Shared package `usb_pkg`:
  - state enum `ulpi_tx_state_t` (IDLE, CMD, DATA, STOP, ABORT)
  - PID constants
  - `TXCMD_PREFIX` value
- One sub-module, `ulpi_beat_detect`: synchronous-reset rising-edge detector producing `beat` from `ulpi_clk`.

## Test plan
- ACK (`tx_pid=4'h2`, `pid_only=1`), `dir=0`, `nxt` high on the first beat → `data_out=8'h42` for one beat, then `stp=1` with `data_out=8'h00` for one beat, then a single `tx_done` pulse.
- DATA0 (`4'h3`) with 3 payload bytes `8'hA5`, `8'h5A`, `8'hFF` (last) → bus shows 43, A5, 5A, FF, 00+stp; `tx_ready` pulses exactly 3 times.
- `nxt` low for 2 beats on byte 2 → 8'h5A held for 3 beats; no extra `tx_ready` pulses.
- `dir` rises during byte 2 → `data_oe=0` on the next `clk`; one `tx_abort` pulse; no `stp`; IDLE after `dir` falls; no `tx_done`.
- `tx_valid=0` on a beat with `nxt` in DATA → one `tx_err` pulse, then STOP with `stp=1`, then `tx_done`.
- `tx_start` while `dir=1` → no bus drive and `tx_busy=1`; TX CMD appears on the first beat after `dir` falls. Reset asserted mid-DATA → all outputs 0 on the next `clk`.
